// File: rtl/buff_regs_bank.sv
// NCH-wide set/clear buffer-register bank with sticky overflow and a snapshot serial readback engine.
// Define BUFF_REGS_PARITY_EN to append an odd-parity bit after the NCH data bits of each readback.
module buff_regs_bank #(
    parameter int NCH = 8,
    parameter int AW  = 3
) (
    input  logic           SIM_CLK,
    input  logic           SIM_RST,
    input  logic           V1,
    input  logic           SET_STB,
    input  logic [AW-1:0]  SET_ADDR,
    input  logic           CLR_STB,
    input  logic [NCH-1:0] CLR_MASK,
    input  logic           RD_START,
    output logic [NCH-1:0] BRD,
    output logic           OVF,
    output logic           RD_BUSY,
    output logic           SER_OUT,
    output logic           SER_VALID,
    output logic           RD_DONE
);

`ifdef BUFF_REGS_PARITY_EN
    localparam int SW = NCH + 1;
`else
    localparam int SW = NCH;
`endif
    localparam logic [AW:0] NBITS = (AW+1)'(SW);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    logic [NCH-1:0] brd_q, brd_d, set_vec, clr_vec;
    logic           ovf_q, ovf_d, addr_ok, ovf_evt;
    state_t         state_q;
    logic [SW-1:0]  shift_q, snap;
    logic [AW:0]    cnt_q;

    always_comb begin
        set_vec = '0;
        addr_ok = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (SET_ADDR == AW'(i)) begin
                set_vec[i] = 1'b1;
                addr_ok    = 1'b1;
            end
        end
        clr_vec = CLR_STB ? CLR_MASK : '0;
        // A bit cleared on the same edge it is set never counts as an overflow.
        ovf_evt = SET_STB && (!addr_ok || (|(brd_q & set_vec & ~clr_vec)));
        brd_d   = SET_STB ? ((brd_q | set_vec) & ~clr_vec) : (brd_q & ~clr_vec);
        ovf_d   = ovf_q;
        if (CLR_STB && (&CLR_MASK)) ovf_d = 1'b0;
        if (ovf_evt) ovf_d = 1'b1;
    end

`ifdef BUFF_REGS_PARITY_EN
    assign snap = {brd_q, ~(^brd_q)};
`else
    assign snap = brd_q;
`endif

    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            brd_q   <= '0;
            ovf_q   <= 1'b0;
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (V1) begin
            brd_q <= brd_d;
            ovf_q <= ovf_d;
            case (state_q)
                IDLE: begin
                    // Snapshot is the pre-edge image, so this edge's set/clear is not in the stream.
                    if (RD_START) begin
                        state_q <= SHIFT;
                        shift_q <= snap;
                        cnt_q   <= NBITS;
                    end
                end
                SHIFT: begin
                    shift_q <= shift_q << 1;
                    cnt_q   <= cnt_q - 1'b1;
                    if (cnt_q == (AW+1)'(1)) state_q <= DONE;
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign BRD       = brd_q;
    assign OVF       = ovf_q;
    assign SER_VALID = (state_q == SHIFT);
    assign SER_OUT   = shift_q[SW-1] & (state_q == SHIFT);
    assign RD_DONE   = (state_q == DONE);
    assign RD_BUSY   = (state_q != IDLE);

endmodule

// File: tb/tb_buff_regs_bank.sv
// Self-checking bench for buff_regs_bank: per-cycle queue-based model plus directed literal checks.
module tb_buff_regs_bank;
    localparam int NCH = 8;
    localparam int AW  = 3;

    logic           SIM_CLK, SIM_RST, V1, SET_STB, CLR_STB, RD_START;
    logic [AW-1:0]  SET_ADDR;
    logic [NCH-1:0] CLR_MASK;
    logic [NCH-1:0] BRD;
    logic           OVF, RD_BUSY, SER_OUT, SER_VALID, RD_DONE;

    logic           s6_stb;
    logic [2:0]     s6_addr;
    logic [5:0]     b6;
    logic           o6, busy6, ser6, sv6, done6;

    int errors = 0;
    int checks = 0;

    buff_regs_bank #(.NCH(NCH), .AW(AW)) dut (
        .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST), .V1(V1),
        .SET_STB(SET_STB), .SET_ADDR(SET_ADDR), .CLR_STB(CLR_STB), .CLR_MASK(CLR_MASK),
        .RD_START(RD_START), .BRD(BRD), .OVF(OVF), .RD_BUSY(RD_BUSY),
        .SER_OUT(SER_OUT), .SER_VALID(SER_VALID), .RD_DONE(RD_DONE)
    );

    buff_regs_bank #(.NCH(6), .AW(3)) u6 (
        .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST), .V1(V1),
        .SET_STB(s6_stb), .SET_ADDR(s6_addr), .CLR_STB(1'b0), .CLR_MASK(6'h00),
        .RD_START(1'b0), .BRD(b6), .OVF(o6), .RD_BUSY(busy6),
        .SER_OUT(ser6), .SER_VALID(sv6), .RD_DONE(done6)
    );

    initial begin
        SIM_CLK = 1'b0;
        forever #5 SIM_CLK = ~SIM_CLK;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: buffer image, sticky flag, queue of bits still to be sent, done flag.
    logic [NCH-1:0] m_brd;
    logic           m_ovf;
    bit             m_q[$];
    bit             m_done;

    initial begin
        logic [NCH-1:0] nb;
        logic           nov;
        m_brd = '0; m_ovf = 1'b0; m_done = 1'b0;
        forever begin
            @(posedge SIM_CLK or negedge SIM_RST);
            if (!SIM_RST) begin
                m_brd = '0; m_ovf = 1'b0; m_done = 1'b0; m_q.delete();
            end else if (V1) begin
                if (m_done) m_done = 1'b0;
                else if (m_q.size() > 0) begin
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) m_done = 1'b1;
                end else if (RD_START) begin
                    for (int i = NCH - 1; i >= 0; i--) m_q.push_back(m_brd[i]);
`ifdef BUFF_REGS_PARITY_EN
                    m_q.push_back(($countones(m_brd) % 2) == 0);
`endif
                end
                nb = m_brd; nov = m_ovf;
                if (CLR_STB && CLR_MASK == '1) nov = 1'b0;
                if (SET_STB) begin
                    if (int'(SET_ADDR) >= NCH) nov = 1'b1;
                    else if (!(CLR_STB && CLR_MASK[SET_ADDR])) begin
                        if (m_brd[SET_ADDR]) nov = 1'b1;
                        nb[SET_ADDR] = 1'b1;
                    end
                end
                if (CLR_STB) nb = nb & ~CLR_MASK;
                m_brd = nb; m_ovf = nov;
            end
        end
    end

    always @(negedge SIM_CLK) begin
        chk("m_BRD", 32'(BRD), 32'(m_brd));
        chk("m_OVF", 32'(OVF), 32'(m_ovf));
        chk("m_SER_VALID", 32'(SER_VALID), 32'(m_q.size() > 0));
        chk("m_SER_OUT", 32'(SER_OUT), (m_q.size() > 0) ? 32'(m_q[0]) : 32'd0);
        chk("m_RD_DONE", 32'(RD_DONE), 32'(m_done));
        chk("m_RD_BUSY", 32'(RD_BUSY), 32'((m_q.size() > 0) || m_done));
    end

    task automatic tick();
        @(posedge SIM_CLK);
        #1;
    endtask

    task automatic step();
        tick();
        SET_STB = 1'b0; CLR_STB = 1'b0; RD_START = 1'b0; s6_stb = 1'b0;
    endtask

    task automatic set_bit(input logic [AW-1:0] a);
        SET_STB = 1'b1; SET_ADDR = a;
        step();
    endtask

    task automatic clr(input logic [NCH-1:0] m);
        CLR_STB = 1'b1; CLR_MASK = m;
        step();
    endtask

    task automatic collect(input int n, output logic [8:0] v);
        v = '0;
        for (int i = 0; i < n; i++) begin
            v = {v[7:0], SER_OUT};
            step();
        end
    endtask

    initial begin
        logic [8:0] v;
        logic [8:0] v2;
        SIM_RST = 1'b0; V1 = 1'b1; SET_STB = 1'b0; SET_ADDR = '0; CLR_STB = 1'b0;
        CLR_MASK = '0; RD_START = 1'b0; s6_stb = 1'b0; s6_addr = '0;
        #12;
        chk("rst_BRD", 32'(BRD), 32'h0);
        chk("rst_OVF", 32'(OVF), 32'h0);
        chk("rst_BUSY", 32'(RD_BUSY), 32'h0);
        chk("rst_VALID", 32'(SER_VALID), 32'h0);
        SIM_RST = 1'b1;
        tick();

        set_bit(3'd3);
        chk("set3_BRD", 32'(BRD), 32'h08);
        chk("set3_OVF", 32'(OVF), 32'h0);
        set_bit(3'd3);
        chk("reset3_OVF", 32'(OVF), 32'h1);
        clr(8'hFF);
        chk("clrall_BRD", 32'(BRD), 32'h00);
        chk("clrall_OVF", 32'(OVF), 32'h0);

        set_bit(3'd5);
        SET_STB = 1'b1; SET_ADDR = 3'd5; CLR_STB = 1'b1; CLR_MASK = 8'h20;
        step();
        chk("conflict_BRD", 32'(BRD), 32'h00);
        chk("conflict_OVF", 32'(OVF), 32'h0);

        s6_stb = 1'b1; s6_addr = 3'd2;
        step();
        chk("n6_set2_BRD", 32'(b6), 32'h04);
        chk("n6_set2_OVF", 32'(o6), 32'h0);
        s6_stb = 1'b1; s6_addr = 3'd7;
        step();
        chk("n6_oor_BRD", 32'(b6), 32'h04);
        chk("n6_oor_OVF", 32'(o6), 32'h1);

        // Readback of 0xA5 with a concurrent set of bit 1 on the accept edge
        clr(8'hFF);
        set_bit(3'd0); set_bit(3'd2); set_bit(3'd5); set_bit(3'd7);
        chk("pre_rd_BRD", 32'(BRD), 32'hA5);
        RD_START = 1'b1; SET_STB = 1'b1; SET_ADDR = 3'd1;
        step();
        chk("rd_live_BRD", 32'(BRD), 32'hA7);
        collect(8, v);
        chk("rd_stream", 32'(v[7:0]), 32'hA5);
`ifdef BUFF_REGS_PARITY_EN
        chk("rd_parity_valid", 32'(SER_VALID), 32'h1);
        chk("rd_parity", 32'(SER_OUT), 32'h1);
        step();
`endif
        chk("rd_done", 32'(RD_DONE), 32'h1);
        chk("rd_done_valid", 32'(SER_VALID), 32'h0);
        step();
        chk("rd_idle_busy", 32'(RD_BUSY), 32'h0);
        chk("rd_idle_done", 32'(RD_DONE), 32'h0);

        // Stall mid-SHIFT; strobes and RD_START during the stall and SHIFT are ignored
        RD_START = 1'b1;
        step();
        collect(3, v);
        V1 = 1'b0; SET_STB = 1'b1; SET_ADDR = 3'd4; RD_START = 1'b1;
        repeat (5) tick();
        chk("stall_BRD", 32'(BRD), 32'hA7);
        chk("stall_valid", 32'(SER_VALID), 32'h1);
        V1 = 1'b1; SET_STB = 1'b0;
        v2 = '0;
        for (int i = 0; i < 5; i++) begin
            v2 = {v2[7:0], SER_OUT};
            RD_START = (i < 4);
            tick();
        end
        RD_START = 1'b0;
        chk("stall_stream", 32'({v[2:0], v2[4:0]}), 32'hA7);
`ifdef BUFF_REGS_PARITY_EN
        chk("stall_parity", 32'(SER_OUT), 32'h0);
        step();
`endif
        chk("stall_done", 32'(RD_DONE), 32'h1);
        step();
        chk("stall_idle", 32'(RD_BUSY), 32'h0);

        // Asynchronous reset after three bits of a readback
        RD_START = 1'b1;
        step();
        collect(3, v);
        #2 SIM_RST = 1'b0;
        #1;
        chk("arst_BRD", 32'(BRD), 32'h0);
        chk("arst_OVF", 32'(OVF), 32'h0);
        chk("arst_BUSY", 32'(RD_BUSY), 32'h0);
        chk("arst_VALID", 32'(SER_VALID), 32'h0);
        chk("arst_SER", 32'(SER_OUT), 32'h0);
        chk("arst_DONE", 32'(RD_DONE), 32'h0);
        @(negedge SIM_CLK);
        @(negedge SIM_CLK);
        SIM_RST = 1'b1;
        tick();
        set_bit(3'd6);
        RD_START = 1'b1;
        step();
        collect(8, v);
        chk("post_rst_stream", 32'(v[7:0]), 32'h40);
`ifdef BUFF_REGS_PARITY_EN
        chk("post_rst_parity", 32'(SER_OUT), 32'h0);
        step();
`endif
        chk("post_rst_done", 32'(RD_DONE), 32'h1);
        step();
        chk("post_rst_idle", 32'(RD_BUSY), 32'h0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
